pe_arbiter: RTL and testbench
=============================

// Module: pe_arbiter
// PURPOSE
//  Parametrised, registered N-input priority encoder / arbiter. It is the next generation of
//  the 3-input gate-level priority encoder. Inputs are a request vector. Output is the winning
//  index plus a one-hot grant, carried on a valid/ready handshake.
//  Two modes: fixed priority (highest index wins) and round-robin.
//  It sits between request sources and a single shared consumer.
// PARAMETERS
//  N            8   number of request lines; N >= 2
//  IDXW         3   width of out_idx; IDXW >= clog2(N)
//  ROUND_ROBIN  0   0 = fixed priority, highest index wins; 1 = rotating priority
// PORTS
//  clock       in   1     rising-edge clock; the only clock
//  reset       in   1     synchronous, active-high reset
//  req         in   N     request vector; bit i = requester i; sampled every clock
//  out_ready   in   1     consumer accepts the current grant this cycle
//  out_valid   out  1     out_idx/out_onehot hold a valid grant
//  out_idx     out  IDXW  binary index of the granted requester
//  out_onehot  out  N     one-hot grant; equals (1 << out_idx) when out_valid, else 0
// BEHAVIOUR
//  - Clocking and reset
//    - One clock. Reset is synchronous and active-high.
//    - Reset values: out_valid=0, out_idx=0, out_onehot=0, ptr=N-1.
//    - Reset asserted mid-hold discards the held grant. No pending state survives reset.
//  - All outputs are registered. There is no combinational path from req or out_ready to any output.
//  - Internal state: ptr (IDXW bits), used only when ROUND_ROBIN=1.
//  - load = !out_valid || out_ready. Two states:
//    - EMPTY (out_valid=0): load is true every cycle.
//    - HOLD (out_valid=1):
//      - out_ready=0: out_idx, out_onehot and out_valid are frozen. req changes are ignored.
//      - out_ready=1: the grant is consumed (accept) and the register reloads the same cycle.
//  - On load, next state is computed from req in that cycle:
//    - |req=1: out_valid<=1, out_idx<=winner, out_onehot<=1<<winner.
//    - req=0: out_valid<=0, out_idx<=0, out_onehot<=0.
//  - Latency is 1 clock from req to grant. Throughput is 1 grant per clock while out_ready=1.
//  - Fixed mode: winner = highest set bit of req. ptr is unused and stays N-1.
//  - Round-robin mode:
//    - Search is descending from a start point s: s, s-1, ..., 0, N-1, ..., s+1. The first set bit wins.
//    - s = (out_idx==0 ? N-1 : out_idx-1) on an accept cycle, otherwise s = ptr. A back-to-back
//      accept+load therefore already uses the rotated pointer, so the same requester never wins
//      twice in a row while others are waiting.
//    - On accept, ptr <= (out_idx==0 ? N-1 : out_idx-1).
//    - Wrap arithmetic is mod N, not mod 2^IDXW. For non-power-of-2 N, index N-1 follows index 0.
//  - Boundary cases:
//    - A single active requester is re-granted every cycle.
//    - A requester dropping req while held still completes its grant; the grant is not revoked.
//    - out_ready=1 with out_valid=0 has no effect beyond a normal load.
//    - Bits of req at index >= N do not exist. out_idx never exceeds N-1.
// TESTING
//  1. Fixed, N=8: req=8'b0010_0110, out_ready=1 -> next cycle out_valid=1, out_idx=5,
//     out_onehot=8'h20.
//  2. Hold: grant idx=5 held with out_ready=0; req changes to 8'h80 -> idx stays 5 for all stall
//     cycles; one clock after out_ready=1, idx=7.
//  3. RR, N=8: req=8'hFF constant, out_ready=1 -> idx sequence 7,6,5,4,3,2,1,0,7 on consecutive
//     cycles.
//  4. RR skip/wrap: req=8'b1000_0001 constant, out_ready=1 -> 7,0,7,0; then req=0 -> out_valid=0
//     one clock later.
//  5. N=3, IDXW=2, fixed: req=3'b011 -> idx=1; req=3'b100 -> idx=2; req=3'b001 -> idx=0.
//     RR with req=3'b111 -> 2,1,0,2.
//  6. Reset mid-hold: out_valid=1, out_ready=0, reset=1 for one clock -> out_valid=0,
//     out_onehot=0, ptr=N-1; next RR grant with req=8'hFF is 7.

Source files
------------

// File: rtl/pe_arbiter_if.sv
// Request/grant bundle between request sources (master side) and the pe_arbiter (slave side).
// Carries the request vector in and the registered grant out on a valid/ready handshake.
interface pe_arbiter_if #(
  parameter int N    = 8,
  parameter int IDXW = 3
);
  logic [N-1:0]    req;
  logic            out_ready;
  logic            out_valid;
  logic [IDXW-1:0] out_idx;
  logic [N-1:0]    out_onehot;

  modport master (
    output req,
    output out_ready,
    input  out_valid,
    input  out_idx,
    input  out_onehot
  );

  modport slave (
    input  req,
    input  out_ready,
    output out_valid,
    output out_idx,
    output out_onehot
  );
endinterface

// File: rtl/pe_arbiter.sv
// Registered N-input priority arbiter: fixed (highest index wins) or rotating priority,
// presenting one grant at a time as index + one-hot on a valid/ready handshake.
module pe_arbiter #(
  parameter int N           = 8,
  parameter int IDXW        = 3,
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  pe_arbiter_if.slave bus
);

  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);
  localparam logic [N-1:0]    ONE  = N'(1);

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [N-1:0]    oh_q, oh_d;

  logic            load;
  logic            accept;
  logic [IDXW-1:0] start;
  logic [IDXW-1:0] winner;
  logic [N-1:0]    lo_mask;
  logic [N-1:0]    req_lo;

  // Predecessor in the descending search order; wraps mod N, not mod 2^IDXW.
  function automatic logic [IDXW-1:0] prev_idx(input logic [IDXW-1:0] x);
    return (x == '0) ? LAST : x - IDXW'(1);
  endfunction

  function automatic logic [IDXW-1:0] highest_set(input logic [N-1:0] v);
    logic [IDXW-1:0] h;
    h = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) h = IDXW'(i);
    end
    return h;
  endfunction

  // A descending circular search from s equals: highest request at or below s,
  // else highest request overall. Fixed mode is the special case s = N-1.
  always_comb begin
    accept = (state_q == HOLD) && bus.out_ready;
    load   = (state_q == EMPTY) || bus.out_ready;
    start  = LAST;
    if (ROUND_ROBIN) begin
      start = accept ? prev_idx(idx_q) : ptr_q;
    end
    lo_mask = '0;
    for (int i = 0; i < N; i++) begin
      lo_mask[i] = (IDXW'(i) <= start);
    end
    req_lo = bus.req & lo_mask;
    winner = (|req_lo) ? highest_set(req_lo) : highest_set(bus.req);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    oh_d    = oh_q;
    ptr_d   = ptr_q;
    if (ROUND_ROBIN && accept) begin
      ptr_d = prev_idx(idx_q);
    end
    if (load) begin
      if (|bus.req) begin
        state_d = HOLD;
        idx_d   = winner;
        oh_d    = ONE << winner;
      end else begin
        state_d = EMPTY;
        idx_d   = '0;
        oh_d    = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= EMPTY;
      idx_q   <= '0;
      oh_q    <= '0;
      ptr_q   <= LAST;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      oh_q    <= oh_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.out_valid  = (state_q == HOLD);
  assign bus.out_idx    = idx_q;
  assign bus.out_onehot = oh_q;

endmodule

// File: tb/tb_pe_arbiter.sv
// Bench for pe_arbiter: four instances (N=8 fixed, N=8 rotating, N=3 fixed, N=3 rotating)
// checked every cycle against a search-order model plus literal expected grants.
module tb_pe_arbiter;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  pe_arbiter_if #(.N(8), .IDXW(3)) if_f8 ();
  pe_arbiter_if #(.N(8), .IDXW(3)) if_r8 ();
  pe_arbiter_if #(.N(3), .IDXW(2)) if_f3 ();
  pe_arbiter_if #(.N(3), .IDXW(2)) if_r3 ();

  pe_arbiter #(.N(8), .IDXW(3), .ROUND_ROBIN(1'b0)) u_f8 (.clock(clock), .reset(reset), .bus(if_f8));
  pe_arbiter #(.N(8), .IDXW(3), .ROUND_ROBIN(1'b1)) u_r8 (.clock(clock), .reset(reset), .bus(if_r8));
  pe_arbiter #(.N(3), .IDXW(2), .ROUND_ROBIN(1'b0)) u_f3 (.clock(clock), .reset(reset), .bus(if_f3));
  pe_arbiter #(.N(3), .IDXW(2), .ROUND_ROBIN(1'b1)) u_r3 (.clock(clock), .reset(reset), .bus(if_r3));

  logic [7:0] req_tb [4];
  logic       rdy_tb [4];
  logic       act_valid [4];
  logic [7:0] act_idx [4];
  logic [7:0] act_oh [4];

  assign if_f8.req = req_tb[0];
  assign if_r8.req = req_tb[1];
  assign if_f3.req = req_tb[2][2:0];
  assign if_r3.req = req_tb[3][2:0];
  assign if_f8.out_ready = rdy_tb[0];
  assign if_r8.out_ready = rdy_tb[1];
  assign if_f3.out_ready = rdy_tb[2];
  assign if_r3.out_ready = rdy_tb[3];

  assign act_valid[0] = if_f8.out_valid;
  assign act_valid[1] = if_r8.out_valid;
  assign act_valid[2] = if_f3.out_valid;
  assign act_valid[3] = if_r3.out_valid;
  assign act_idx[0] = {5'd0, if_f8.out_idx};
  assign act_idx[1] = {5'd0, if_r8.out_idx};
  assign act_idx[2] = {6'd0, if_f3.out_idx};
  assign act_idx[3] = {6'd0, if_r3.out_idx};
  assign act_oh[0] = if_f8.out_onehot;
  assign act_oh[1] = if_r8.out_onehot;
  assign act_oh[2] = {5'd0, if_f3.out_onehot};
  assign act_oh[3] = {5'd0, if_r3.out_onehot};

  int n_cmp = 0;
  int n_bad = 0;

  function automatic int n_of(input int d);
    return (d < 2) ? 8 : 3;
  endfunction

  function automatic bit rr_of(input int d);
    return (d % 2) == 1;
  endfunction

  // Model: a grant is held until taken; on each load the requests are scanned in
  // descending circular order from a start point and the first one found wins.
  bit m_valid [4];
  int m_idx [4];
  int m_ptr [4];
  bit mdl_live = 1'b0;

  always @(posedge clock) begin
    for (int d = 0; d < 4; d++) begin
      int n;
      int s;
      int w;
      int j;
      n = n_of(d);
      if (reset) begin
        m_valid[d] <= 1'b0;
        m_idx[d]   <= 0;
        m_ptr[d]   <= n - 1;
      end else if (!(m_valid[d] && !rdy_tb[d])) begin
        if (!rr_of(d))      s = n - 1;
        else if (m_valid[d]) s = (m_idx[d] + n - 1) % n;
        else                 s = m_ptr[d];
        if (rr_of(d) && m_valid[d]) m_ptr[d] <= (m_idx[d] + n - 1) % n;
        w = -1;
        for (int k = 0; k < n; k++) begin
          j = (s - k + n) % n;
          if (w < 0 && req_tb[d][j]) w = j;
        end
        m_valid[d] <= (w >= 0);
        m_idx[d]   <= (w >= 0) ? w : 0;
      end
    end
    mdl_live <= 1'b1;
  end

  always @(negedge clock) begin
    if (mdl_live) begin
      for (int d = 0; d < 4; d++) begin
        logic [7:0] e_oh;
        e_oh = m_valid[d] ? (8'h1 << m_idx[d]) : 8'h0;
        n_cmp++;
        if (act_valid[d] !== m_valid[d] || act_idx[d] !== 8'(m_idx[d]) || act_oh[d] !== e_oh) begin
          n_bad++;
          $display("FAIL model dut%0d t=%0t: got v=%0b idx=%0d oh=%h, want v=%0b idx=%0d oh=%h",
                   d, $time, act_valid[d], act_idx[d], act_oh[d], m_valid[d], m_idx[d], e_oh);
        end
      end
    end
  end

  task automatic check_lit(input int d, input bit v, input int idx, input string name);
    logic [7:0] e_oh;
    e_oh = v ? (8'h1 << idx) : 8'h0;
    n_cmp++;
    if (act_valid[d] !== v || act_idx[d] !== 8'(idx) || act_oh[d] !== e_oh) begin
      n_bad++;
      $display("FAIL %s: got v=%0b idx=%0d oh=%h, want v=%0b idx=%0d oh=%h",
               name, act_valid[d], act_idx[d], act_oh[d], v, idx, e_oh);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  initial begin
    int rr8_seq [9];
    int rr3_seq [4];
    rr8_seq = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    rr3_seq = '{2, 1, 0, 2};
    reset = 1'b1;
    for (int d = 0; d < 4; d++) begin
      req_tb[d] = 8'h00;
      rdy_tb[d] = 1'b1;
    end
    step();
    step();
    for (int d = 0; d < 4; d++) check_lit(d, 1'b0, 0, "reset_state");
    reset = 1'b0;

    // Fixed N=8: highest set bit, then hold under stall
    req_tb[0] = 8'b0010_0110;
    step();
    check_lit(0, 1'b1, 5, "fixed_0x26");
    rdy_tb[0] = 1'b0;
    req_tb[0] = 8'h80;
    for (int k = 0; k < 3; k++) begin
      step();
      check_lit(0, 1'b1, 5, "hold_frozen");
    end
    rdy_tb[0] = 1'b1;
    step();
    check_lit(0, 1'b1, 7, "hold_release");
    req_tb[0] = 8'h04;
    step();
    check_lit(0, 1'b1, 2, "single_req_a");
    step();
    check_lit(0, 1'b1, 2, "single_req_b");
    req_tb[0] = 8'h00;
    step();
    check_lit(0, 1'b0, 0, "fixed_idle");

    // Rotating N=8, all requesting
    req_tb[1] = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      step();
      check_lit(1, 1'b1, rr8_seq[k], "rr8_all");
    end

    // Reset while holding
    rdy_tb[1] = 1'b0;
    step();
    check_lit(1, 1'b1, 7, "rr8_stall");
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_lit(1, 1'b0, 0, "reset_mid_hold");
    rdy_tb[1] = 1'b1;
    step();
    check_lit(1, 1'b1, 7, "rr8_after_reset");

    // Rotating skip/wrap between 7 and 0
    req_tb[1] = 8'b1000_0001;
    step();
    check_lit(1, 1'b1, 0, "rr8_wrap_0");
    step();
    check_lit(1, 1'b1, 7, "rr8_wrap_7");
    step();
    check_lit(1, 1'b1, 0, "rr8_wrap_0b");
    req_tb[1] = 8'h00;
    step();
    check_lit(1, 1'b0, 0, "rr8_idle");

    // N=3 fixed and rotating
    req_tb[2] = 8'b011;
    step();
    check_lit(2, 1'b1, 1, "f3_011");
    req_tb[2] = 8'b100;
    step();
    check_lit(2, 1'b1, 2, "f3_100");
    req_tb[2] = 8'b001;
    step();
    check_lit(2, 1'b1, 0, "f3_001");
    req_tb[2] = 8'h00;
    req_tb[3] = 8'b111;
    for (int k = 0; k < 4; k++) begin
      step();
      check_lit(3, 1'b1, rr3_seq[k], "rr3_all");
    end
    req_tb[3] = 8'h00;
    step();

    // Mixed traffic with stalls, checked by the model only
    for (int k = 0; k < 80; k++) begin
      for (int d = 0; d < 4; d++) begin
        req_tb[d] = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 3) == 0) req_tb[d] = 8'h00;
        rdy_tb[d] = ($urandom_range(0, 3) != 0);
      end
      reset = (k == 40);
      step();
    end
    reset = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
